nios_sys_pio_gen: RTL

Parametrised general-purpose PIO Avalon-MM slave for the Nios system. It succeeds the fixed 8-bit output-only LED PIO with the following additions:
- configurable width;
- per-bit direction;
- synchronised inputs;
- atomic set/clear of output bits;
- edge capture with a maskable interrupt.

It sits on the Nios data master interconnect and drives board LEDs, buttons and general-purpose I/O headers.

---
 rtl/nios_sys_pio_gen.sv | 68 ++++++
 1 files changed

// File: rtl/nios_sys_pio_gen.sv
// nios_sys_pio_gen: Avalon-MM PIO slave with per-bit direction, synchronised inputs,
// atomic set/clear and edge capture with a maskable interrupt.
module nios_sys_pio_gen #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET = '1,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic [WIDTH-1:0] r_data, r_dir, r_mask, r_cap, r_sync1, r_sync, r_prev;
  logic [1:0]       r_arm;
  logic             w_wr;
  logic [WIDTH-1:0] w_wd, w_edge, w_set, w_clr, w_rd;
  assign w_wr   = chipselect & ~write_n;
  assign w_wd   = writedata[WIDTH-1:0];
  assign w_edge = EDGE_TYPE == 0 ? r_sync & ~r_prev :
                  EDGE_TYPE == 1 ? ~r_sync & r_prev : r_sync ^ r_prev;
  // Edges are ignored until the synchroniser and in_prev hold real samples
  assign w_set  = r_arm == 2'd3 ? w_edge & ~r_dir : '0;
  assign w_clr  = (w_wr && address == 3'd3) ? w_wd : '0;
  assign w_rd   = address == 3'd0 ? (r_data & r_dir) | (r_sync & ~r_dir) :
                  address == 3'd1 ? r_dir :
                  address == 3'd2 ? r_mask :
                  address == 3'd3 ? r_cap : '0;
  assign readdata = 32'(w_rd);
  assign out_port = r_data;
  assign oe       = r_dir;
  assign irq      = |(r_cap & r_mask);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= RESET_VALUE;
      r_dir   <= DIR_RESET;
      r_mask  <= '0;
      r_cap   <= '0;
      r_sync1 <= '0;
      r_sync  <= '0;
      r_prev  <= '0;
      r_arm   <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync  <= r_sync1;
      r_prev  <= r_sync;
      r_arm   <= r_arm + {1'b0, r_arm != 2'd3};
      r_cap   <= (r_cap & ~w_clr) | w_set;
      if (w_wr) begin
        case (address)
          3'd0: r_data <= w_wd;
          3'd1: r_dir  <= w_wd;
          3'd2: r_mask <= w_wd;
          3'd4: r_data <= r_data | w_wd;
          3'd5: r_data <= r_data & ~w_wd;
          default: ;
        endcase
      end
    end
  end
endmodule
